// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: FSM state encodings and
// the minimum legal stability count.
package debounce_pkg;

   localparam logic [1:0] ST_IDLE_LO = 2'd0;
   localparam logic [1:0] ST_CHK_HI  = 2'd1;
   localparam logic [1:0] ST_IDLE_HI = 2'd2;
   localparam logic [1:0] ST_CHK_LO  = 2'd3;

   localparam int MIN_STABLE = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; resets to zero.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] s1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/debounce_edge.sv
// Debounces a raw switch input: synchronizes it, requires STABLE_CNT
// consecutive samples at a new level, then updates dout with a rise/fall pulse.
module debounce_edge
   import debounce_pkg::*;
#(
   parameter int STABLE_CNT = 10,
   parameter int CNT_W      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   if (STABLE_CNT < MIN_STABLE) begin : g_bad_stable
      $error("debounce_edge: STABLE_CNT must be at least %0d", MIN_STABLE);
   end
   if ((2 ** CNT_W) <= STABLE_CNT) begin : g_bad_cnt_w
      $error("debounce_edge: CNT_W too narrow for STABLE_CNT");
   end

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic             sync;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;

   sync_2ff #(.W(1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (sync)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE_LO;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            ST_IDLE_LO: begin
               if (sync) begin
                  state <= ST_CHK_HI;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt   <= '0;
               end
            end
            ST_CHK_HI: begin
               if (!sync) begin
                  state <= ST_IDLE_LO;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= ST_IDLE_HI;
                  rise  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + CNT_ONE;
               end
            end
            ST_IDLE_HI: begin
               if (!sync) begin
                  state <= ST_CHK_LO;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt   <= '0;
               end
            end
            ST_CHK_LO: begin
               if (sync) begin
                  state <= ST_IDLE_HI;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= ST_IDLE_LO;
                  fall  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + CNT_ONE;
               end
            end
         endcase
      end
   end

   // The encoding puts the debounced level in bit 1 and "checking" in bit 0,
   // so both outputs come straight from the state flops.
   assign dout = state[1];
   assign busy = state[0];

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: vector table, corner-case sequences
// and randomized stimulus against a run-length reference model.
module tb_debounce_edge;

   localparam int STABLE_CNT = 10;
   localparam int CNT_W      = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic dout, rise, fall, busy;

   int total = 0;
   int bad   = 0;

   debounce_edge #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .dout (dout),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   always #5 clk = ~clk;

   // Reference: din reaches the checker two edges late; dout flips once the
   // number of consecutive samples differing from it reaches STABLE_CNT.
   bit m_hist0, m_hist1;
   int m_run;
   bit m_dout, m_rise, m_fall;

   task automatic model_reset();
      m_hist0 = 0; m_hist1 = 0; m_run = 0;
      m_dout = 0; m_rise = 0; m_fall = 0;
   endtask

   task automatic model_edge(input bit d);
      bit s;
      s = m_hist1;
      m_hist1 = m_hist0;
      m_hist0 = d;
      m_rise = 0;
      m_fall = 0;
      if (s == m_dout) m_run = 0;
      else begin
         m_run++;
         if (m_run == STABLE_CNT) begin
            m_dout = s;
            m_rise = s;
            m_fall = !s;
            m_run  = 0;
         end
      end
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // One clock: drive din away from the edge, advance the model, check at negedge.
   task automatic step(input bit d);
      din = d;
      @(posedge clk);
      if (!rst) model_edge(d);
      @(negedge clk);
      chk("model_dout", dout, m_dout);
      chk("model_rise", rise, m_rise);
      chk("model_fall", fall, m_fall);
      chk("model_busy", busy, m_run > 0);
   endtask

   task automatic assert_reset(input bit d);
      din = d;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_dout", dout, 1'b0);
      chk("rst_rise", rise, 1'b0);
      chk("rst_fall", fall, 1'b0);
      chk("rst_busy", busy, 1'b0);
   endtask

   task automatic do_reset(input bit d);
      @(negedge clk);
      assert_reset(d);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Holds din and counts steps until rise; a fall on the way or an expired budget fails.
   task automatic wait_rise(input string name, input bit d, input int exp);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      while (!seen && n < 40) begin
         step(d);
         n++;
         if (fall) chk({name, "_no_fall"}, fall, 1'b0);
         if (rise) seen = 1;
      end
      chk_int({name, "_steps"}, seen ? n : -1, exp);
   endtask

   typedef struct {
      bit din;
      bit dout;
      bit rise;
      bit fall;
      bit busy;
   } vec_t;

   vec_t tbl[28];

   initial begin
      int rise_cnt;
      int hold;

      // Press (rows 0-13) then release (rows 14-27); row i drives edge E(i mod 14).
      for (int i = 0; i < 14; i++) begin
         tbl[i]      = '{1'b1, i >= 11, i == 11, 1'b0, (i >= 2 && i <= 10)};
         tbl[i + 14] = '{1'b0, i < 11, 1'b0, i == 11, (i >= 2 && i <= 10)};
      end

      model_reset();
      din = 1'b0;
      rst = 1'b1;
      #1;
      chk("init_dout", dout, 1'b0);
      chk("init_busy", busy, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) step(1'b0);

      for (int i = 0; i < 28; i++) begin
         din = tbl[i].din;
         @(posedge clk);
         model_edge(tbl[i].din);
         @(negedge clk);
         chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
         chk($sformatf("tbl%0d_rise", i), rise, tbl[i].rise);
         chk($sformatf("tbl%0d_fall", i), fall, tbl[i].fall);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      end

      // Reset with din high, then a full debounce after release.
      do_reset(1'b1);
      wait_rise("rst_release", 1'b1, 12);
      step(1'b1);
      chk("rst_release_pulse_end", rise, 1'b0);
      chk("rst_release_dout", dout, 1'b1);

      // Bounce: toggles every 3 cycles, then holds high.
      do_reset(1'b0);
      rise_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step(((i / 3) % 2) == 0);
         if (rise) rise_cnt++;
      end
      chk_int("bounce_no_rise", rise_cnt, 0);
      chk("bounce_dout_low", dout, 1'b0);
      wait_rise("bounce", 1'b1, 12);

      // Glitch just as the count reaches its last value.
      do_reset(1'b0);
      for (int i = 0; i <= 8; i++) step(1'b1);
      step(1'b0);
      step(1'b1);
      chk("glitch_busy_at_cnt9", busy, 1'b1);
      step(1'b1);
      chk("glitch_busy_drop", busy, 1'b0);
      chk("glitch_dout", dout, 1'b0);
      chk("glitch_no_rise", rise, 1'b0);
      wait_rise("glitch_recover", 1'b1, 10);

      // Reset in the middle of a release check.
      do_reset(1'b1);
      wait_rise("mid_pre", 1'b1, 12);
      repeat (2) step(1'b1);
      for (int i = 0; i <= 6; i++) step(1'b0);
      chk("mid_busy", busy, 1'b1);
      chk("mid_dout", dout, 1'b1);
      assert_reset(1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         chk("mid_hold_fall", fall, 1'b0);
      end
      rst = 1'b0;
      wait_rise("mid_release", 1'b1, 12);

      // Random runs with occasional reset.
      do_reset(1'b0);
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 39) == 0) do_reset(1'($urandom_range(0, 1)));
         hold = $urandom_range(1, 14);
         din = 1'($urandom_range(0, 1));
         for (int j = 0; j < hold; j++) step(din);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL timeout: simulation ran past its time limit");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Front-end conditioning stage that cleans a raw, asynchronous, bouncy switch/button input.
- Produces a stable level that drives the d input of the downstream d_latch stage, plus single-cycle rise/fall pulses for counters and FSMs.
- Structure: 2-flop synchronizer, then a 4-state stability-check FSM with a cycle counter.

Parameters:
- STABLE_CNT, 10: consecutive synchronized samples at the new level required before the output changes. Legal range is 2 or more.
- CNT_W, 4: counter width. Must satisfy 2**CNT_W > STABLE_CNT.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  raw switch input, asynchronous to clk, may bounce.
- dout  output  1  debounced level; feeds d_latch d.
- rise  output  1  one-cycle pulse when dout goes 0->1.
- fall  output  1  one-cycle pulse when dout goes 1->0.
- busy  output  1  high while a candidate level change is being checked.

Behaviour:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- rst=1 immediately forces:
  - both synchronizer flops to 0;
  - state to IDLE_LO and cnt to 0;
  - dout, rise, fall and busy to 0.
- All outputs are registered. No combinational path exists from din to any output.
- Synchronizer: s1<=din, s2<=s1. "sync" means s2 as sampled at an edge.
- FSM states, 2-bit encoding: IDLE_LO=0, CHK_HI=1, IDLE_HI=2, CHK_LO=3.
- IDLE_LO:
  - sync=1 -> CHK_HI, cnt<=1.
  - Otherwise stay, cnt<=0.
- CHK_HI:
  - sync=0 -> IDLE_LO, cnt<=0. No pulse.
  - sync=1 and cnt==STABLE_CNT-1 -> IDLE_HI, dout<=1, rise<=1, cnt<=0.
  - sync=1 otherwise -> cnt<=cnt+1.
- IDLE_HI and CHK_LO mirror IDLE_LO and CHK_HI with the polarity inverted. Completing CHK_LO gives dout<=0, fall<=1.
- rise and fall are high for exactly one cycle. They are cleared at the next edge unless re-asserted, and re-assertion is impossible within STABLE_CNT cycles. rise and fall are never high together.
- busy is registered and equals 1 exactly while the state is CHK_HI or CHK_LO.
- Latency:
  - din stable high, first sampled at edge E0.
  - dout and rise go high after edge E(STABLE_CNT+1).
  - rise falls after edge E(STABLE_CNT+2).
  - Default: dout is high 11 edges after first sampling.
- Bounce: any sync reversal during CHK returns to the previous IDLE state. cnt is cleared, and dout keeps its old value. The stability count restarts from 1 on the next change.
- cnt never exceeds STABLE_CNT-1 and never wraps.
- Reset mid-check or with dout=1:
  - Outputs drop to 0 immediately, with no fall pulse.
  - If din is still high after release, a full debounce runs and a rise pulse is produced.
- din pulses shorter than one clock period may be missed. This is acceptable.

Decomposition:
- Shared package debounce_pkg holds:
  - state encodings ST_IDLE_LO, ST_CHK_HI, ST_IDLE_HI, ST_CHK_LO;
  - MIN_STABLE=2, checked by an elaboration-time assertion.
- One natural sub-module: sync_2ff, a generic 2-flop synchronizer with async active-high reset to 0. It is reused for other asynchronous inputs.
- FSM, counter and pulse registers live in debounce_edge.

Test Plan:
- Reset check: rst=1 with din=1 -> dout=rise=fall=busy=0 immediately. Release rst -> rise for one cycle after edge 11, and dout=1 from then on.
- Clean press: din 0->1 held, STABLE_CNT=10 -> busy=1 after edge 2. Then at edge 11: dout=1, rise=1 for one cycle, busy=0.
- Bounce rejection: din toggles 1,0,1,0 every 3 cycles, then holds 1 -> no rise during the bounce. A single rise occurs 10 stable sync samples after the last toggle.
- Release: from dout=1, din 1->0 held -> fall=1 for one cycle at edge 11, and dout=0. rise stays 0 throughout.
- Glitch at threshold: in CHK_HI with cnt=9, sync=0 for one sample -> state returns to IDLE_LO, cnt=0, dout stays 0, no rise pulse.
- Mid-operation reset: assert rst while cnt=5 in CHK_LO with dout=1 -> dout=0 immediately and no fall pulse. After release with din=1, a rise occurs 11 edges later.
